// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP layer sequencer and the ping-pong activation memory.
// addr_w() is the single source of the memory address width.
package mlp_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_SHIFT  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    LAUNCH = S_LAUNCH,
    WAIT   = S_WAIT,
    WRITE  = S_WRITE,
    SHIFT  = S_SHIFT,
    DONE   = S_DONE
  } seq_state_t;

  function automatic int addr_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mlp_layer_sequencer_idx.sv
// Nested neuron/layer index counters with terminal-count flags.
// A layer step always rewinds the neuron index, so it never wraps by overflow.
module mlp_idx_counter
  import mlp_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 3,
  localparam int ADDR_W  = addr_w(N),
  localparam int LAYER_W = $clog2(M) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               neuron_step,
  input  logic               layer_step,
  output logic [ADDR_W-1:0]  neuron_idx,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               neuron_last,
  output logic               layer_last
);

  assign neuron_last = (neuron_idx == ADDR_W'(N - 1));
  assign layer_last  = (layer_idx == LAYER_W'(M - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      neuron_idx <= '0;
      layer_idx  <= '0;
    end else if (layer_step) begin
      neuron_idx <= '0;
      if (!layer_last) layer_idx <= layer_idx + LAYER_W'(1);
    end else if (neuron_step && !neuron_last) begin
      neuron_idx <= neuron_idx + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Control FSM that time-multiplexes one shared neuron over N neurons x M layers,
// writing results into the output bank and promoting it with shift after each layer.
//
//   state  | meaning
//   IDLE   | waiting for start
//   LAUNCH | neuron_start pulse for the current neuron
//   WAIT   | waiting for neuron_valid (no timeout)
//   WRITE  | write_enable, address = neuron index
//   SHIFT  | promote output bank to input bank, next layer
//   DONE   | one-cycle done pulse, back to IDLE
module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 3,
  localparam int ADDR_W  = addr_w(N),
  localparam int LAYER_W = $clog2(M) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               neuron_valid,
  output logic               neuron_start,
  output logic               write_enable,
  output logic [ADDR_W-1:0]  write_address,
  output logic               shift,
  output logic [ADDR_W-1:0]  neuron_idx,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               done
);

  seq_state_t state, state_nxt;
  logic       clear, neuron_step, layer_step, neuron_last, layer_last;

  mlp_idx_counter #(.N(N), .M(M)) u_idx (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .neuron_step (neuron_step),
    .layer_step  (layer_step),
    .neuron_idx  (neuron_idx),
    .layer_idx   (layer_idx),
    .neuron_last (neuron_last),
    .layer_last  (layer_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    clear       = 1'b0;
    neuron_step = 1'b0;
    layer_step  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LAUNCH;
          clear     = 1'b1;
        end
      end
      LAUNCH: state_nxt = WAIT;
      WAIT: begin
        if (neuron_valid) state_nxt = WRITE;
      end
      WRITE: begin
        if (neuron_last) begin
          state_nxt = SHIFT;
        end else begin
          state_nxt   = LAUNCH;
          neuron_step = 1'b1;
        end
      end
      SHIFT: begin
        layer_step = 1'b1;
        state_nxt  = layer_last ? DONE : LAUNCH;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs: decoded from the state register only, never from neuron_valid.
  assign neuron_start  = (state == LAUNCH);
  assign write_enable  = (state == WRITE);
  assign shift         = (state == SHIFT);
  assign done          = (state == DONE);
  assign busy          = (state == LAUNCH) || (state == WAIT) ||
                         (state == WRITE)  || (state == SHIFT);
  assign write_address = neuron_idx;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Bench for mlp_layer_sequencer: two instances (N=4,M=3 and N=2,M=1), each with a
// neuron responder and an event scoreboard fed by a per-run reference model.
`timescale 1ns/1ps
module tb_mlp_layer_sequencer;

  // kind: 0 launch, 1 write, 2 shift, 3 done
  typedef struct {
    int kind;
    int addr;
    int layer;
  } ev_t;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  int   k_max    = 1;
  bit   stray_en = 1'b0;
  int   cyc      = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input int g, input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL i%0d %s: got %0d, expected %0d (cycle %0d)", g, name, got, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_inst
    localparam int NN = (g == 0) ? 4 : 2;
    localparam int MM = (g == 0) ? 3 : 1;
    localparam int AW = $clog2(NN) + 1;
    localparam int LW = $clog2(MM) + 1;

    logic          start;
    logic          neuron_valid = 1'b0;
    logic          neuron_start, write_enable, shift, busy, done;
    logic [AW-1:0] write_address, neuron_idx;
    logic [LW-1:0] layer_idx;

    ev_t exp_q[$];
    bit  model_busy = 1'b0;
    bit  pending    = 1'b0;
    bit  last_real  = 1'b0;
    bit  reset_chk  = 1'b0;
    int  start_cyc  = 0;
    int  sum_k      = 0;
    int  cnt        = 0;
    int  writes     = 0;

    assign start = (g == 0) ? start0 : start1;

    mlp_layer_sequencer #(.N(NN), .M(MM)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .neuron_valid  (neuron_valid),
      .neuron_start  (neuron_start),
      .write_enable  (write_enable),
      .write_address (write_address),
      .shift         (shift),
      .neuron_idx    (neuron_idx),
      .layer_idx     (layer_idx),
      .busy          (busy),
      .done          (done)
    );

    always @(negedge clk) begin
      ev_t e;
      int  kind;
      bit  was_busy, was_pending, real_v, done_due, stray;
      was_busy    = model_busy;
      was_pending = pending;

      check(g, "no_we_shift_overlap", longint'(write_enable & shift), 0);
      check(g, "no_start_we_overlap", longint'(neuron_start & write_enable), 0);

      if (reset_chk) begin
        check(g, "reset_pulses", longint'({neuron_start, write_enable, shift, busy, done}), 0);
        check(g, "reset_neuron_idx", longint'(neuron_idx), 0);
        check(g, "reset_layer_idx", longint'(layer_idx), 0);
        check(g, "reset_write_address", longint'(write_address), 0);
        reset_chk = 1'b0;
      end

      done_due = (exp_q.size() > 0) && (exp_q[0].kind == 3);
      if (model_busy && cyc > start_cyc)
        check(g, "busy", longint'(busy), longint'(!done_due));

      if (neuron_start || write_enable || shift || done) begin
        kind = done ? 3 : shift ? 2 : write_enable ? 1 : 0;
        if (exp_q.size() == 0) begin
          check(g, "unexpected_event_kind", longint'(kind), -1);
        end else begin
          e = exp_q.pop_front();
          check(g, "event_kind", longint'(kind), longint'(e.kind));
          if (e.kind <= 1) begin
            check(g, "neuron_idx", longint'(neuron_idx), longint'(e.addr));
            check(g, "layer_idx", longint'(layer_idx), longint'(e.layer));
          end
          if (e.kind == 0 && e.addr == 0 && e.layer == 0)
            check(g, "first_launch_latency", longint'(cyc - start_cyc), 1);
          if (e.kind == 1) begin
            check(g, "write_address", longint'(write_address), longint'(e.addr));
            check(g, "write_after_valid", longint'(last_real), 1);
            writes++;
          end
          if (e.kind == 2)
            check(g, "shift_layer_idx", longint'(layer_idx), longint'(e.layer));
          if (e.kind == 3) begin
            check(g, "done_latency", longint'(cyc - start_cyc),
                  longint'(1 + sum_k + 2 * NN * MM + MM));
            check(g, "write_count", longint'(writes), longint'(NN * MM));
            model_busy = 1'b0;
          end
        end
      end

      // Shared-neuron responder: valid k cycles after each launch, optional stray pulses.
      real_v = 1'b0;
      if (neuron_start) begin
        cnt     = (k_max <= 1) ? 1 : int'($urandom_range(k_max, 1));
        sum_k  += cnt;
        pending = 1'b1;
      end else if (pending) begin
        cnt--;
        if (cnt == 0) begin
          real_v  = 1'b1;
          pending = 1'b0;
        end
      end
      stray = stray_en && !was_pending && (neuron_start || write_enable || shift || !busy)
              && ($urandom_range(1, 0) == 1);
      neuron_valid = real_v | stray;
      last_real    = real_v;

      if (rst) begin
        exp_q.delete();
        model_busy   = 1'b0;
        pending      = 1'b0;
        last_real    = 1'b0;
        neuron_valid = 1'b0;
        reset_chk    = 1'b1;
      end else if (start && !was_busy) begin
        model_busy = 1'b1;
        start_cyc  = cyc;
        sum_k      = 0;
        writes     = 0;
        for (int l = 0; l < MM; l++) begin
          for (int n = 0; n < NN; n++) begin
            exp_q.push_back('{0, n, l});
            exp_q.push_back('{1, n, l});
          end
          exp_q.push_back('{2, 0, l});
        end
        exp_q.push_back('{3, 0, 0});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_both();
    start0 = 1'b1;
    start1 = 1'b1;
    tick(1);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while ((gen_inst[0].model_busy || gen_inst[1].model_busy) && i < budget) begin
      tick(1);
      i++;
    end
    check(0, "run_completes_in_budget",
          longint'(gen_inst[0].model_busy | gen_inst[1].model_busy), 0);
  endtask

  initial begin
    int i;
    tick(3);
    rst = 1'b0;
    tick(2);

    // nominal: valid one cycle after each launch, no strays
    pulse_both();
    wait_idle(2000);
    tick(2);

    // random delays, stray valids, start re-pulsed mid-run
    k_max    = 5;
    stray_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      pulse_both();
      for (int j = 0; j < 6; j++) begin
        tick(int'($urandom_range(12, 3)));
        pulse_both();
      end
      wait_idle(3000);
      tick(3);
    end

    // start held from the DONE cycle into IDLE: only the IDLE sample launches
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    i = 0;
    while (!gen_inst[0].done && i < 1000) begin
      tick(1);
      i++;
    end
    check(0, "done_reached", longint'(i < 1000), 1);
    start0 = 1'b1;
    tick(2);
    start0 = 1'b0;
    wait_idle(2000);
    tick(2);

    // reset while waiting on layer 1, neuron 2
    stray_en = 1'b0;
    start0   = 1'b1;
    tick(1);
    start0 = 1'b0;
    i = 0;
    while (!(gen_inst[0].busy && !gen_inst[0].neuron_start && !gen_inst[0].write_enable &&
             !gen_inst[0].shift && gen_inst[0].layer_idx == 1 && gen_inst[0].neuron_idx == 2)
           && i < 1000) begin
      tick(1);
      i++;
    end
    check(0, "reached_wait_l1_n2", longint'(i < 1000), 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    stray_en = 1'b1;
    pulse_both();
    wait_idle(2000);
    tick(2);

    // a couple more random runs on both instances
    for (int r = 0; r < 2; r++) begin
      pulse_both();
      wait_idle(2000);
      tick(int'($urandom_range(4, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
